seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; accepted only while ready=1.
REQ-005 SHALL have port abort  input  1  synchronous cancel of an operation in progress.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement (radix-2 Booth), 0 = unsigned.
REQ-007 SHALL have port a  input  N  multiplicand.
REQ-008 SHALL have port b  input  N  multiplier.
REQ-009 SHALL have port ready  output  1  idle, able to accept start.
REQ-010 SHALL have port done  output  1  one-cycle pulse, product valid.
REQ-011 SHALL have port product  output  2N  registered result.
REQ-012 SHALL have ports add, sub, shift  output  1 each  datapath strobes, for observation.

Function
REQ-013 SHALL implement states IDLE, ADDING, SHIFTING, DONE; any other encoding goes to IDLE.
REQ-014 In IDLE: ready=1; start=1 and abort=0 at an edge latches M=a, Q=b, mode=signed_mode, clears A (N+1 bits) and Q_1, loads count=N, moves to ADDING.
REQ-015 Operand or signed_mode changes after acceptance SHALL NOT affect the running operation.
REQ-016 In ADDING, unsigned: Q[0]=1 -> A=A+zext(M), add=1; else A unchanged.
REQ-017 In ADDING, signed: {Q[0],Q_1}=10 -> A=A-sext(M), sub=1; 01 -> A=A+sext(M), add=1; 00/11 -> no change.
REQ-018 A arithmetic SHALL be N+1 bits wide, modulo 2^(N+1); no overflow flag.
REQ-019 ADDING always moves to SHIFTING after one cycle.
REQ-020 In SHIFTING, shift=1: unsigned -> logical right shift of {A,Q}; signed -> arithmetic right shift of {A,Q,Q_1}; count decrements.
REQ-021 From SHIFTING: count>1 before decrement -> ADDING; count=1 -> DONE, product loaded with low 2N bits of shifted {A,Q} on the same edge.
REQ-022 In DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-023 Latency SHALL be fixed: start accepted at edge 0, done high in the cycle after edge 2N, ready high again after edge 2N+1.
REQ-024 product SHALL hold its value until the next completed operation; it SHALL NOT change on acceptance or abort.
REQ-025 start outside IDLE SHALL be ignored; start held high gives back-to-back operations with one idle cycle between them.
REQ-026 abort=1 in ADDING, SHIFTING or DONE SHALL force IDLE at the next edge. No done pulse in ADDING/SHIFTING; the pulse in DONE still completes, and product is already loaded.
REQ-027 abort and start both high in IDLE SHALL stay IDLE; abort wins.
REQ-028 add, sub and shift SHALL be mutually exclusive; all strobes are low in IDLE and DONE.

Reset
REQ-029 n_rst=0 SHALL immediately force IDLE, count=N, A=0, Q=0, Q_1=0, M=0 and product=0.
REQ-030 While n_rst=0, ready=1 and done=add=sub=shift=0.
REQ-031 Reset mid-operation SHALL discard the operation with no done pulse.

Verification
REQ-032 N=8, unsigned, a=255, b=255, start 1 cycle -> done in the cycle after edge 16, product=0xFE01, 8 shift strobes.
REQ-033 N=8, signed, a=0x80, b=0x80 -> product=0x4000; signed a=0xFF, b=0x05 -> product=0xFFFB.
REQ-034 N=8, unsigned, b=0x00 -> zero add strobes, product=0x0000, latency unchanged at 2N+1.
REQ-035 abort at edge 5 of an operation -> IDLE after the next edge, no done pulse, product keeps its previous value.
REQ-036 n_rst low mid-operation -> immediate ready=1, product=0; start held high with a=3, b=4 -> product=12, then 12 again on the back-to-back operation with one idle cycle between.
REQ-037 N=4, signed, a=0x8, b=0x7 -> product=0xC8 (-56); random sweep of both modes against a reference model.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: unsigned, or radix-2 Booth for two's complement.
// One ADDING and one SHIFTING cycle per operand bit; product is registered and held until the next completion.
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           n_rst,
  input  logic           start,
  input  logic           abort,
  input  logic           signed_mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           add,
  output logic           sub,
  output logic           shift
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ADDING   = 2'd1;
  localparam logic [1:0] SHIFTING = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]    state;
  logic [N-1:0]  m;
  logic [N-1:0]  q;
  logic [N:0]    acc;
  logic          q_1;
  logic          mode;
  logic [CW-1:0] count;

  logic [N:0]    ext_m;
  logic          booth_add;
  logic          booth_sub;
  logic [N:0]    sh_acc;
  logic [N-1:0]  sh_q;

  // M is zero- or sign-extended into the N+1 bit accumulator depending on the latched mode
  assign ext_m     = mode ? {m[N-1], m} : {1'b0, m};
  assign booth_add = mode ? (~q[0] & q_1) : q[0];
  assign booth_sub = mode & q[0] & ~q_1;

  assign sh_acc = {mode & acc[N], acc[N:1]};
  assign sh_q   = {acc[0], q[N-1:1]};

  assign ready = (state == IDLE);
  assign done  = (state == DONE);
  assign add   = (state == ADDING) && !abort && booth_add;
  assign sub   = (state == ADDING) && !abort && booth_sub;
  assign shift = (state == SHIFTING) && !abort;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      q_1     <= 1'b0;
      mode    <= 1'b0;
      count   <= CW'(N);
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            m     <= a;
            q     <= b;
            mode  <= signed_mode;
            acc   <= '0;
            q_1   <= 1'b0;
            count <= CW'(N);
            state <= ADDING;
          end
        end
        ADDING: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            if (add) begin
              acc <= acc + ext_m;
            end else if (sub) begin
              acc <= acc - ext_m;
            end
            state <= SHIFTING;
          end
        end
        SHIFTING: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            acc   <= sh_acc;
            q     <= sh_q;
            q_1   <= q[0];
            count <= count - CW'(1);
            if (count == CW'(1)) begin
              product <= {sh_acc[N-1:0], sh_q};
              state   <= DONE;
            end else begin
              state <= ADDING;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: directed vectors plus a reference-model sweep, N=8 and N=4 instances.
module tb_seq_multiplier;

  logic        clock = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, signed_mode = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        ready, done, add, sub, shift;
  logic [15:0] product;

  logic        start4 = 1'b0, abort4 = 1'b0, sm4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, done4, add4, sub4, shift4;
  logic [7:0]  product4;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp4_q[$];

  always #5 clock = ~clock;

  seq_multiplier #(.N(8)) dut (
    .clock(clock), .n_rst(n_rst), .start(start), .abort(abort),
    .signed_mode(signed_mode), .a(a), .b(b), .ready(ready), .done(done),
    .product(product), .add(add), .sub(sub), .shift(shift)
  );

  seq_multiplier #(.N(4)) dut4 (
    .clock(clock), .n_rst(n_rst), .start(start4), .abort(abort4),
    .signed_mode(sm4), .a(a4), .b(b4), .ready(ready4), .done(done4),
    .product(product4), .add(add4), .sub(sub4), .shift(shift4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] sx, sy;
    if (s) begin
      sx = $signed({{8{x[7]}}, x});
      sy = $signed({{8{y[7]}}, y});
      return 16'(sx * sy);
    end
    return {8'b0, x} * {8'b0, y};
  endfunction

  // Pops the expected result whenever either instance presents a done pulse.
  task automatic monitor();
    forever begin
      @(negedge clock);
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done8", 64'(product), 64'hDEAD);
        else chk("product8", 64'(product), 64'(exp_q.pop_front()));
      end
      if (done4) begin
        if (exp4_q.size() == 0) chk("unexpected_done4", 64'(product4), 64'hDEAD);
        else chk("product4", 64'(product4), 64'(exp4_q.pop_front()));
      end
      if (add | sub | shift)
        chk("strobe_onehot", 64'(add + sub + shift), 64'd1);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ready) return;
    end
    chk("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic im, input int exp_add);
    int cyc, na, nsh;
    bit got;
    wait_ready();
    a = ia; b = ib; signed_mode = im; start = 1'b1;
    exp_q.push_back(ref_prod(ia, ib, im));
    @(posedge clock);
    #1;
    start = 1'b0; a = ~ia; b = ib ^ 8'h5A; signed_mode = ~im;
    cyc = 0; na = 0; nsh = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (add) na++;
      if (shift) nsh++;
      if (done) got = 1;
      else begin
        @(posedge clock);
        cyc++;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(cyc), 64'd16);
    chk("shift_count", 64'(nsh), 64'd8);
    if (exp_add >= 0) chk("add_count", 64'(na), 64'(exp_add));
    @(posedge clock);
    #1;
    chk("ready_after", 64'(ready), 64'd1);
  endtask

  initial begin
    int cyc;
    bit got;
    fork
      monitor();
    join_none

    #12;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_strobes", 64'({add, sub, shift}), 64'd0);
    @(negedge clock);
    n_rst = 1'b1;

    run_op(8'hFF, 8'hFF, 1'b0, 8);
    run_op(8'h80, 8'h80, 1'b1, -1);
    run_op(8'hFF, 8'h05, 1'b1, 2);
    run_op(8'h37, 8'h00, 1'b0, 0);
    chk("zero_product", 64'(product), 64'd0);

    // Reset mid-operation: immediate idle, cleared product, no done pulse
    run_op(8'd13, 8'd11, 1'b0, -1);
    wait_ready();
    a = 8'd100; b = 8'd50; signed_mode = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1 n_rst = 1'b0;
    #1;
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_product", 64'(product), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    @(negedge clock);
    n_rst = 1'b1;
    repeat (20) @(negedge clock);

    // Start held high: two back-to-back operations, one idle cycle between
    a = 8'd3; b = 8'd4; signed_mode = 1'b0; start = 1'b1;
    exp_q.push_back(16'd12);
    exp_q.push_back(16'd12);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clock);
      if (done) got = 1;
    end
    chk("b2b_first", 64'(got), 64'd1);
    got = 0; cyc = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (done) got = 1;
    end
    start = 1'b0;
    chk("b2b_second", 64'(got), 64'd1);
    chk("b2b_gap", 64'(cyc), 64'd18);

    // Abort at edge 5: no done, product unchanged
    wait_ready();
    a = 8'd9; b = 8'd9; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (4) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    chk("abort_ready", 64'(ready), 64'd1);
    repeat (20) @(negedge clock);
    chk("abort_product", 64'(product), 64'd12);

    // Abort beats start in idle
    abort = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_start_idle", 64'(ready), 64'd1);
    abort = 1'b0; start = 1'b0;

    for (int i = 0; i < 16; i++)
      run_op(8'($urandom), 8'($urandom), 1'(i & 1), -1);

    // N=4 instance
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      a4 = k == 0 ? 4'h8 : 4'hF; b4 = k == 0 ? 4'h7 : 4'hF;
      sm4 = (k == 0); start4 = 1'b1;
      exp4_q.push_back(k == 0 ? 8'hC8 : 8'hE1);
      @(posedge clock);
      #1 start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; sm4 = ~sm4;
      got = 0; cyc = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clock);
        if (done4) got = 1;
        else begin
          @(posedge clock);
          cyc++;
        end
      end
      chk("n4_done", 64'(got), 64'd1);
      chk("n4_latency", 64'(cyc), 64'd8);
    end

    repeat (3) @(negedge clock);
    chk("queue8_drained", 64'(exp_q.size()), 64'd0);
    chk("queue4_drained", 64'(exp4_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
